// File: rtl/dcache_2way_ctrl.sv
// Two-way set-associative, write-back, write-allocate data cache controller.
// Holds tag/data storage, per-set LRU, byte-enabled CPU writes and hit/miss counters.
module dcache_2way_ctrl #(
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_MemRead_i,
  input  logic                    cpu_MemWrite_i,
  input  logic [31:0]             cpu_addr_i,
  input  logic [31:0]             cpu_data_i,
  input  logic [3:0]              cpu_be_i,
  output logic [31:0]             cpu_data_o,
  output logic                    cpu_stall_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  output logic [31:0]             mem_addr_o,
  output logic [8*LINE_BYTES-1:0] mem_data_o,
  input  logic [8*LINE_BYTES-1:0] mem_data_i,
  input  logic                    mem_ack_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG    = 32 - IDX - OFF;
  localparam int WRD    = OFF - 2;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_e;

  state_e               state_q, state_d;
  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [1:0][SETS-1:0] dirty_q, dirty_d;
  logic [SETS-1:0]      lru_q, lru_d;
  logic                 victim_way_q, victim_way_d;
  logic [IDX-1:0]       idx_q, idx_d;
  logic [TAG-1:0]       req_tag_q, req_tag_d;
  logic                 refilled_q, refilled_d;
  logic                 mem_enable_q, mem_enable_d;
  logic                 mem_write_q, mem_write_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]    mem_data_q, mem_data_d;
  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;

  logic [TAG-1:0]    tag_mem  [2][SETS];
  logic [LINE_W-1:0] data_mem [2][SETS];

  logic              arr_we, tag_we, arr_way;
  logic [IDX-1:0]    arr_idx;
  logic [LINE_W-1:0] arr_line;

  logic [TAG-1:0]    req_tag, victim_tag;
  logic [IDX-1:0]    req_idx;
  logic [WRD-1:0]    req_word;
  logic              req, match0, match1, hit, hit_way, victim_way, victim_dirty;
  logic [LINE_W-1:0] hit_line, merged_line, victim_line;
  logic              unused_addr_bits;

  assign req_tag  = cpu_addr_i[31 -: TAG];
  assign req_idx  = cpu_addr_i[OFF +: IDX];
  assign req_word = cpu_addr_i[2 +: WRD];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign req     = cpu_MemRead_i | cpu_MemWrite_i;
  assign match0  = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign match1  = valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit     = req && (state_q == IDLE) && (match0 || match1);
  assign hit_way = match1;
  assign hit_line = data_mem[hit_way][req_idx];

  // Fill invalid ways first (way0 before way1), otherwise evict the LRU way.
  assign victim_way   = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign victim_dirty = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];
  assign victim_tag   = tag_mem[victim_way][req_idx];
  assign victim_line  = data_mem[victim_way][req_idx];

  assign cpu_data_o  = hit ? hit_line[32*int'(req_word) +: 32] : 32'd0;
  assign cpu_stall_o = req && ((state_q != IDLE) || !hit);

  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (cpu_be_i[b]) merged_line[32*int'(req_word) + 8*b +: 8] = cpu_data_i[8*b +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    lru_d        = lru_q;
    victim_way_d = victim_way_q;
    idx_d        = idx_q;
    req_tag_d    = req_tag_q;
    refilled_d   = refilled_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    arr_we       = 1'b0;
    tag_we       = 1'b0;
    arr_way      = hit_way;
    arr_idx      = req_idx;
    arr_line     = merged_line;
    unique case (state_q)
      IDLE: begin
        refilled_d = 1'b0;
        if (hit) begin
          lru_d[req_idx] = ~hit_way;
          if (!refilled_q) hit_cnt_d = hit_cnt_q + 32'd1;
          if (cpu_MemWrite_i) begin
            arr_we = 1'b1;
            dirty_d[hit_way][req_idx] = 1'b1;
          end
        end else if (req) begin
          miss_cnt_d   = miss_cnt_q + 32'd1;
          victim_way_d = victim_way;
          idx_d        = req_idx;
          req_tag_d    = req_tag;
          mem_enable_d = 1'b1;
          if (victim_dirty) begin
            state_d     = WB;
            mem_write_d = 1'b1;
            mem_addr_d  = {victim_tag, req_idx, {OFF{1'b0}}};
            mem_data_d  = victim_line;
          end else begin
            state_d     = FILL;
            mem_write_d = 1'b0;
            mem_addr_d  = {req_tag, req_idx, {OFF{1'b0}}};
          end
        end
      end
      WB: begin
        if (mem_ack_i) begin
          state_d     = FILL;
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag_q, idx_q, {OFF{1'b0}}};
        end
      end
      FILL: begin
        if (mem_ack_i) begin
          arr_we   = 1'b1;
          tag_we   = 1'b1;
          arr_way  = victim_way_q;
          arr_idx  = idx_q;
          arr_line = mem_data_i;
          valid_d[victim_way_q][idx_q] = 1'b1;
          dirty_d[victim_way_q][idx_q] = 1'b0;
          lru_d[idx_q] = ~victim_way_q;
          refilled_d   = 1'b1;
          mem_enable_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
      refilled_q   <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      lru_q        <= lru_d;
      refilled_q   <= refilled_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Miss bookkeeping and storage arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk_i) begin
    victim_way_q <= victim_way_d;
    idx_q        <= idx_d;
    req_tag_q    <= req_tag_d;
    if (arr_we) data_mem[arr_way][arr_idx] <= arr_line;
    if (tag_we) tag_mem[arr_way][arr_idx] <= req_tag_q;
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Directed bench for dcache_2way_ctrl: default geometry with a line memory model,
// plus a SETS=64 / LINE_BYTES=64 instance driven by hand.
module tb_dcache_2way_ctrl;
  localparam int LW      = 256;
  localparam int LW2     = 512;
  localparam int ACK_LAT = 4;

  logic          clk_i, rst_i;
  logic          cpu_MemRead_i, cpu_MemWrite_i;
  logic [31:0]   cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]    cpu_be_i;
  logic          cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]   mem_addr_o, hit_cnt_o, miss_cnt_o;
  logic [LW-1:0] mem_data_o, mem_data_i;

  logic           b_rd, b_wr, b_stall, b_mem_en, b_mem_wr, b_ack;
  logic [31:0]    b_addr, b_wdata, b_rdata, b_mem_addr, b_hit, b_miss;
  logic [3:0]     b_be;
  logic [LW2-1:0] b_mem_do, b_mem_di;

  int n_assert = 0;
  int n_fail   = 0;

  logic [LW-1:0] mem_lines [logic [31:0]];
  int            wb_count = 0, fill_count = 0, spur_req = 0;
  logic [31:0]   last_wb_addr, last_fill_addr;
  logic [LW-1:0] last_wb_data;

  dcache_2way_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_be_i(cpu_be_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  dcache_2way_ctrl #(.LINE_BYTES(64), .SETS(64)) dut_big (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_MemRead_i(b_rd), .cpu_MemWrite_i(b_wr),
    .cpu_addr_i(b_addr), .cpu_data_i(b_wdata), .cpu_be_i(b_be),
    .cpu_data_o(b_rdata), .cpu_stall_o(b_stall),
    .mem_enable_o(b_mem_en), .mem_write_o(b_mem_wr), .mem_addr_o(b_mem_addr),
    .mem_data_o(b_mem_do), .mem_data_i(b_mem_di), .mem_ack_i(b_ack),
    .hit_cnt_o(b_hit), .miss_cnt_o(b_miss)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [LW-1:0] gen_line(input logic [31:0] la);
    logic [LW-1:0] l;
    for (int w = 0; w < LW/32; w++) l[32*w +: 32] = (la + 32'(4*w)) ^ 32'h1122_3300;
    return l;
  endfunction

  // Line memory: acks ACK_LAT edges after enable rises or after the previous ack.
  initial begin : mem_responder
    int cnt;
    int spur_seen;
    cnt = 0;
    spur_seen = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (mem_ack_i) mem_ack_i = 1'b0;
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        mem_data_i = '1;
        mem_ack_i = 1'b1;
      end else if (mem_enable_o) begin
        cnt++;
        if (cnt == ACK_LAT) begin
          cnt = 0;
          if (mem_write_o) begin
            mem_lines[mem_addr_o] = mem_data_o;
            wb_count++;
            last_wb_addr = mem_addr_o;
            last_wb_data = mem_data_o;
          end else begin
            mem_data_i = mem_lines.exists(mem_addr_o) ? mem_lines[mem_addr_o] : gen_line(mem_addr_o);
            fill_count++;
            last_fill_addr = mem_addr_o;
          end
          mem_ack_i = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output int stalls);
    cpu_MemWrite_i = wr;
    cpu_MemRead_i  = rd;
    cpu_addr_i     = addr;
    cpu_data_i     = wdata;
    cpu_be_i       = be;
    stalls = 0;
    #1;
    while (cpu_stall_o && stalls < 100) begin
      @(posedge clk_i); #1;
      stalls++;
    end
    n_assert++;
    if (cpu_stall_o) begin
      n_fail++;
      $display("FAIL access_timeout addr=%h: still stalled after %0d cycles, required completion", addr, stalls);
    end
    rdata = cpu_data_o;
    @(posedge clk_i); #1;
    cpu_MemWrite_i = 1'b0;
    cpu_MemRead_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_assert++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_enable got %b want 0", mem_enable_o); end
    n_assert++; if (mem_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b want 0", mem_write_o); end
    n_assert++; if (mem_addr_o !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr_o); end
    n_assert++; if (mem_data_o !== '0) begin n_fail++; $display("FAIL reset_mem_data got nonzero want 0"); end
    n_assert++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
    n_assert++; if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_idle_cpu got stall=%b data=%h want 0/0", cpu_stall_o, cpu_data_o); end
    n_assert++; if (b_mem_en !== 1'b0 || b_hit !== 32'd0) begin n_fail++; $display("FAIL reset_big got en=%b hit=%0d want 0/0", b_mem_en, b_hit); end
    cpu_MemRead_i = 1'b1;
    cpu_addr_i = 32'h40;
    #1;
    n_assert++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall_follows_req got %b want 1", cpu_stall_o); end
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_cold_read();
    logic [31:0] rd;
    int st;
    cpu_MemRead_i = 1'b1;
    cpu_addr_i = 32'h40;
    #1;
    n_assert++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL cold_detect_stall got %b want 1", cpu_stall_o); end
    @(posedge clk_i); #1;
    st = 1;
    n_assert++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) begin n_fail++; $display("FAIL cold_fill_req got en=%b wr=%b want 1/0", mem_enable_o, mem_write_o); end
    n_assert++; if (mem_addr_o !== 32'h40) begin n_fail++; $display("FAIL cold_fill_addr got %h want 00000040", mem_addr_o); end
    n_assert++; if (miss_cnt_o !== 32'd1) begin n_fail++; $display("FAIL cold_miss_cnt got %0d want 1", miss_cnt_o); end
    while (cpu_stall_o && st < 50) begin
      @(posedge clk_i); #1;
      st++;
    end
    n_assert++; if (st !== 6) begin n_fail++; $display("FAIL cold_stall_len got %0d want 6", st); end
    n_assert++; if (cpu_data_o !== 32'h1122_3340) begin n_fail++; $display("FAIL cold_data got %h want 11223340", cpu_data_o); end
    @(posedge clk_i); #1;
    cpu_MemRead_i = 1'b0;
    n_assert++; if (hit_cnt_o !== 32'd0 || mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL cold_after got hit=%0d en=%b want 0/0", hit_cnt_o, mem_enable_o); end
    access(1'b0, 1'b1, 32'h40, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 0 || rd !== 32'h1122_3340) begin n_fail++; $display("FAIL repeat_read got stall=%0d data=%h want 0/11223340", st, rd); end
    n_assert++; if (hit_cnt_o !== 32'd1) begin n_fail++; $display("FAIL repeat_hit_cnt got %0d want 1", hit_cnt_o); end
  endtask

  task automatic test_write_merge();
    logic [31:0] rd;
    int st;
    access(1'b1, 1'b0, 32'h44, 32'hAABB_CCDD, 4'b0101, rd, st);
    n_assert++; if (st !== 0) begin n_fail++; $display("FAIL wr_hit_stall got %0d want 0", st); end
    access(1'b0, 1'b1, 32'h44, 32'd0, 4'd0, rd, st);
    n_assert++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL wr_merge_data got %h want 11BB33DD", rd); end
    n_assert++; if (hit_cnt_o !== 32'd3) begin n_fail++; $display("FAIL wr_merge_hit_cnt got %0d want 3", hit_cnt_o); end
  endtask

  task automatic test_lru_conflict();
    logic [31:0] rd;
    int st, wb0;
    wb0 = wb_count;
    access(1'b0, 1'b1, 32'h040, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 0) begin n_fail++; $display("FAIL lru_A1 got stall=%0d want 0", st); end
    access(1'b0, 1'b1, 32'h240, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 6 || rd !== 32'h1122_3140) begin n_fail++; $display("FAIL lru_B got stall=%0d data=%h want 6/11223140", st, rd); end
    access(1'b0, 1'b1, 32'h040, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 0) begin n_fail++; $display("FAIL lru_A2 got stall=%0d want 0", st); end
    access(1'b0, 1'b1, 32'h440, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 6 || rd !== 32'h1122_3740 || last_fill_addr !== 32'h440) begin n_fail++; $display("FAIL lru_C got stall=%0d data=%h fill=%h want 6/11223740/440", st, rd, last_fill_addr); end
    n_assert++; if (wb_count !== wb0) begin n_fail++; $display("FAIL lru_no_wb got %0d writebacks want %0d", wb_count, wb0); end
    access(1'b0, 1'b1, 32'h040, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 0 || rd !== 32'h1122_3340) begin n_fail++; $display("FAIL lru_A_kept got stall=%0d data=%h want 0/11223340", st, rd); end
    n_assert++; if (miss_cnt_o !== 32'd3 || hit_cnt_o !== 32'd6) begin n_fail++; $display("FAIL lru_counts got miss=%0d hit=%0d want 3/6", miss_cnt_o, hit_cnt_o); end
    access(1'b0, 1'b1, 32'h240, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 6) begin n_fail++; $display("FAIL lru_B_evicted got stall=%0d want 6", st); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd;
    logic [LW-1:0] exp_line;
    int st, wb0;
    access(1'b1, 1'b1, 32'h040, 32'hDEAD_BEEF, 4'b1111, rd, st);
    n_assert++; if (st !== 0) begin n_fail++; $display("FAIL dirty_wrA got stall=%0d want 0", st); end
    access(1'b0, 1'b1, 32'h240, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 0) begin n_fail++; $display("FAIL dirty_rdB got stall=%0d want 0", st); end
    wb0 = wb_count;
    exp_line = gen_line(32'h40);
    exp_line[31:0]  = 32'hDEAD_BEEF;
    exp_line[63:32] = 32'h11BB_33DD;
    access(1'b0, 1'b1, 32'h440, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 10 || rd !== 32'h1122_3740) begin n_fail++; $display("FAIL dirty_C got stall=%0d data=%h want 10/11223740", st, rd); end
    n_assert++; if (wb_count !== wb0 + 1 || last_wb_addr !== 32'h40) begin n_fail++; $display("FAIL dirty_wb_addr got n=%0d addr=%h want %0d/00000040", wb_count, last_wb_addr, wb0 + 1); end
    n_assert++; if (last_wb_data !== exp_line) begin n_fail++; $display("FAIL dirty_wb_data got low words %h want %h", last_wb_data[63:0], exp_line[63:0]); end
    n_assert++; if (last_fill_addr !== 32'h440) begin n_fail++; $display("FAIL dirty_fill_addr got %h want 00000440", last_fill_addr); end
    access(1'b0, 1'b1, 32'h040, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 6 || rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dirty_reload got stall=%0d data=%h want 6/DEADBEEF", st, rd); end
    access(1'b0, 1'b1, 32'h044, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 0 || rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL dirty_reload_w1 got stall=%0d data=%h want 0/11BB33DD", st, rd); end
    n_assert++; if (miss_cnt_o !== 32'd6 || hit_cnt_o !== 32'd9) begin n_fail++; $display("FAIL dirty_counts got miss=%0d hit=%0d want 6/9", miss_cnt_o, hit_cnt_o); end
  endtask

  task automatic test_write_allocate();
    logic [31:0] rd;
    int st;
    access(1'b1, 1'b0, 32'h864, 32'h1234_5678, 4'b1111, rd, st);
    n_assert++; if (st !== 6 || last_fill_addr !== 32'h860) begin n_fail++; $display("FAIL walloc_miss got stall=%0d fill=%h want 6/00000860", st, last_fill_addr); end
    access(1'b0, 1'b1, 32'h864, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 0 || rd !== 32'h1234_5678) begin n_fail++; $display("FAIL walloc_word got stall=%0d data=%h want 0/12345678", st, rd); end
    access(1'b0, 1'b1, 32'h860, 32'd0, 4'd0, rd, st);
    n_assert++; if (rd !== 32'h1122_3B60) begin n_fail++; $display("FAIL walloc_neighbour got %h want 11223B60", rd); end
    access(1'b1, 1'b0, 32'h864, 32'hFFFF_FFFF, 4'b0000, rd, st);
    access(1'b0, 1'b1, 32'h864, 32'd0, 4'd0, rd, st);
    n_assert++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL be_zero_write got %h want 12345678", rd); end
    n_assert++; if (miss_cnt_o !== 32'd7 || hit_cnt_o !== 32'd13) begin n_fail++; $display("FAIL walloc_counts got miss=%0d hit=%0d want 7/13", miss_cnt_o, hit_cnt_o); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd;
    int st, guard;
    cpu_MemRead_i = 1'b1;
    cpu_addr_i = 32'h1000;
    guard = 0;
    while (!mem_enable_o && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    n_assert++; if (mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL rstfill_started got en=%b want 1", mem_enable_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    n_assert++; if (mem_enable_o !== 1'b0 || mem_addr_o !== 32'd0) begin n_fail++; $display("FAIL rstfill_mem got en=%b addr=%h want 0/0", mem_enable_o, mem_addr_o); end
    n_assert++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rstfill_counters got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
    n_assert++; if (cpu_stall_o !== 1'b1 || cpu_data_o !== 32'd0) begin n_fail++; $display("FAIL rstfill_cpu got stall=%b data=%h want 1/0", cpu_stall_o, cpu_data_o); end
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    spur_req++;
    repeat (3) @(posedge clk_i);
    #1;
    n_assert++; if (mem_enable_o !== 1'b0 || miss_cnt_o !== 32'd0 || cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL spurious_ack got en=%b miss=%0d stall=%b want 0/0/0", mem_enable_o, miss_cnt_o, cpu_stall_o); end
    access(1'b0, 1'b1, 32'h040, 32'd0, 4'd0, rd, st);
    n_assert++; if (st !== 6 || rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rstfill_cold_again got stall=%0d data=%h want 6/DEADBEEF", st, rd); end
    n_assert++; if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rstfill_counts got miss=%0d hit=%0d want 1/0", miss_cnt_o, hit_cnt_o); end
  endtask

  task automatic big_miss(input logic [31:0] addr, input logic [LW2-1:0] line,
                          output logic [31:0] seen_addr, output logic [31:0] rdata);
    int guard;
    b_rd = 1'b1;
    b_addr = addr;
    guard = 0;
    #1;
    while (!b_mem_en && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    seen_addr = b_mem_addr;
    @(negedge clk_i);
    b_mem_di = line;
    b_ack = 1'b1;
    @(negedge clk_i);
    b_ack = 1'b0;
    guard = 0;
    while (b_stall && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    rdata = b_rdata;
    @(posedge clk_i); #1;
    b_rd = 1'b0;
  endtask

  task automatic test_param_geometry();
    logic [LW2-1:0] line;
    logic [31:0] seen, rd;
    line = '0;
    line[31:0]    = 32'h0BAD_0000;
    line[511:480] = 32'hCAFE_0015;
    big_miss(32'h0000_1FFC, line, seen, rd);
    n_assert++; if (seen !== 32'h0000_1FC0) begin n_fail++; $display("FAIL big_fill_addr got %h want 00001FC0", seen); end
    n_assert++; if (rd !== 32'hCAFE_0015) begin n_fail++; $display("FAIL big_word15 got %h want CAFE0015", rd); end
    line[511:480] = 32'hBEEF_00FF;
    big_miss(32'hFFFF_FFFC, line, seen, rd);
    n_assert++; if (seen !== 32'hFFFF_FFC0 || rd !== 32'hBEEF_00FF) begin n_fail++; $display("FAIL big_top_wrap got addr=%h data=%h want FFFFFFC0/BEEF00FF", seen, rd); end
    b_rd = 1'b1;
    b_addr = 32'h0000_1FFC;
    #1;
    n_assert++; if (b_stall !== 1'b0 || b_rdata !== 32'hCAFE_0015) begin n_fail++; $display("FAIL big_set63_hit got stall=%b data=%h want 0/CAFE0015", b_stall, b_rdata); end
    b_addr = 32'h0000_1FC0;
    #1;
    n_assert++; if (b_rdata !== 32'h0BAD_0000) begin n_fail++; $display("FAIL big_word0 got %h want 0BAD0000", b_rdata); end
    @(posedge clk_i); #1;
    b_rd = 1'b0;
    n_assert++; if (b_hit !== 32'd1 || b_miss !== 32'd2) begin n_fail++; $display("FAIL big_counts got hit=%0d miss=%0d want 1/2", b_hit, b_miss); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_be_i = '0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    b_mem_di = '0; b_ack = 1'b0;
    test_reset();
    test_cold_read();
    test_write_merge();
    test_lru_conflict();
    test_dirty_evict();
    test_write_allocate();
    test_reset_mid_fill();
    test_param_geometry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_2way_ctrl.md
# dcache_2way_ctrl

Parametrised two-way set-associative, write-back, write-allocate data cache controller with integrated tag/data storage, per-set LRU replacement, byte-enabled CPU writes and hit/miss counters. It sits between the pipeline's MEM stage and the line-wide data memory, stalling the CPU on misses. It succeeds the direct-mapped controller: same CPU/memory handshake, generalised line size and set count, plus associativity.

## Interface
- LINE_BYTES, 32: bytes per line; power of two, at least 8; LINE_W = 8*LINE_BYTES; OFF = log2(LINE_BYTES).
- SETS, 16: sets per way; power of two, at least 2; IDX = log2(SETS); TAG = 32-IDX-OFF.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cpu_MemRead_i  in  1  read request.
- cpu_MemWrite_i  in  1  write request; has priority if both request lines are high.
- cpu_addr_i  in  32  byte address; bits [1:0] are ignored.
- cpu_data_i  in  32  write data.
- cpu_be_i  in  4  byte enables for writes; bit i selects byte i.
- cpu_data_o  out  32  read data; 0 when there is no hit.
- cpu_stall_o  out  1  stall the CPU.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = write-back, 0 = fill.
- mem_addr_o  out  32  line address; low OFF bits are 0.
- mem_data_o  out  LINE_W  victim line for write-back.
- mem_data_i  in  LINE_W  fill line.
- mem_ack_i  in  1  one-cycle completion pulse.
- hit_cnt_o  out  32  count of accesses that hit first time.
- miss_cnt_o  out  32  count of misses.

## Operation
- Address fields: tag = addr[31:IDX+OFF], index = addr[IDX+OFF-1:OFF], word = addr[OFF-1:2].
- Per set and way: valid, dirty, tag, data. Per set: one lru bit, naming the least-recently-used way.
- Lookup is combinational on both ways. hit = req & state==IDLE & a way is valid with a matching tag. Both ways matching cannot occur.
- Read hit: cpu_data_o = word of the hit way, with zero wait.
- Write hit: at the clock edge, merge the enabled bytes of cpu_data_i into the word and set dirty.
- Every hit sets lru[set] = other way.
- Victim selection, in order: way0 if invalid, else way1 if invalid, else way lru[set].
- State IDLE, on req & ~hit at a clock edge:
  - increment miss_cnt.
  - latch victim way, index, request tag and victim tag.
  - if the victim is valid & dirty, go to WB with mem_enable=1, write=1, addr={victim tag, index, 0}, mem_data_o = victim line.
  - otherwise go to FILL with mem_enable=1, write=0, addr={req tag, index, 0}.
- WB, on mem_ack_i: go to FILL; mem_enable stays 1, write=0, addr switches to the fill address.
- FILL, on mem_ack_i:
  - write mem_data_i into the victim way, with valid=1, dirty=0, tag=request tag.
  - set lru[set] = other way.
  - set the refilled flag; mem_enable=0; go to DONE.
- DONE: one cycle, then IDLE. The held request now hits and completes as a normal read or write hit. It does not count as a hit because the refilled flag is set; the flag clears on that IDLE cycle.
- hit_cnt increments on each IDLE edge with hit & ~refilled. Both counters wrap modulo 2^32.
- mem_ack_i is ignored in IDLE and DONE.
- The CPU must hold address, data, enables and request stable while stalled.
- cpu_be_i = 0 on a write hit: the line is unchanged but is still marked dirty.

## Timing
- Reset values:
  - state IDLE.
  - all valid, dirty and lru bits 0.
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o 0.
  - counters 0.
  - cpu_data_o 0.
  - cpu_stall_o = req, combinationally.
  - Data and tag arrays are not reset.
- cpu_stall_o = req & (state != IDLE | ~hit), combinational.
- Memory outputs are registered, asserted on the edge after the miss is detected. mem_enable_o deasserts on the edge that samples the FILL ack.
- Clean miss, ack sampled k cycles after mem_enable_o rises: stall lasts k+2 cycles (FILL k, DONE 1, detect 1). A dirty miss adds the write-back ack latency.
- Reset asserted mid-WB/FILL: all outputs and state clear immediately (asynchronous). Dirty data is discarded and the in-flight memory transaction is abandoned.

## Test plan
- Defaults; memory acks 4 cycles after enable.
- Cold read of 0x0000_0040: miss_cnt=1, then FILL with mem_addr_o=0x40, mem_write_o=0. Stall lasts 6 cycles; cpu_data_o = memory word; hit_cnt=0. A repeat read gives zero-wait hit, hit_cnt=1.
- Write 0xAABBCCDD with be=4'b0101 to 0x44 after the line is loaded (old word 0x11223344): a read returns 0x11BB33DD, and the line is dirty.
- Conflict and LRU at index 2:
  - Sequence: read 0x040 (A), read 0x240 (B), read A, read 0x440 (C).
  - C evicts B (LRU); A still hits afterwards.
  - miss_cnt=3.
- Dirty eviction:
  - Setup: write A, fill B, read B.
  - Access C: mem_write_o=1 with addr 0x040 and the modified line, then a fill from 0x440.
  - Reading A afterwards misses and returns the written data from memory.
- Reset pulse during FILL: mem_enable_o=0 at once, all sets miss, counters read 0. A spurious mem_ack_i in IDLE has no effect.
- SETS=64, LINE_BYTES=64: addr 0x1FC0 maps to index 63, word 15. The fill address is 0x1FC0, and the top-of-range wrap is correct.
